// File: rtl/mmio_pwm_periph_if.sv
// Data-bus view between the core and the PWM peripheral.
// Latency: ReadData and hit are combinational from DataAdr and the register state.
// Backpressure: none; the core issues one access per cycle and never stalls.
// Signals:
//   MemWrite  store strobe, one cycle per store
//   DataAdr   byte address
//   WriteData store data
//   ReadData  load data, 0 outside the register window
//   hit       DataAdr falls inside the 32-byte register window
interface mmio_pwm_periph_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        hit;

  modport master (output MemWrite, DataAdr, WriteData, input ReadData, hit);
  modport slave  (input MemWrite, DataAdr, WriteData, output ReadData, hit);
endinterface

// File: rtl/mmio_pwm_periph.sv
// Memory-mapped LED/PWM register block on the core's data bus.
// Latency: loads combinational; stores take effect on the next clk edge; pwm/wrap registered.
// Backpressure: none; every access completes in the cycle it is presented.
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   bus (slave)      MemWrite/DataAdr/WriteData in, ReadData/hit out
//   leds             LED register
//   pwm_out          {31'b0, pwm}
//   wrap             one-cycle pulse after the counter wraps
module mmio_pwm_periph #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0200,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  mmio_pwm_periph_if.slave        bus,
  output logic [3:0]              leds,
  output logic [31:0]             pwm_out,
  output logic                    wrap
);

  localparam int unsigned    PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [3:0]       leds_q,   leds_d;
  logic [15:0]      period_q, period_d;
  logic [15:0]      duty_q,   duty_d;
  logic             en_q,     en_d;
  logic             done_q,   done_d;
  logic [15:0]      cnt_q,    cnt_d;
  logic [PRE_W-1:0] pre_q,    pre_d;
  logic [15:0]      per_sh_q, per_sh_d;
  logic [15:0]      duty_sh_q, duty_sh_d;
  logic             pwm_q,    pwm_d;
  logic             wrap_q,   wrap_d;

  logic        hit_w;
  logic        wr_w;
  logic [2:0]  off_w;
  logic        tick_w;
  logic        wrap_evt_w;
  logic [31:0] rdata_w;

  // Byte-lane bits and the upper store-data bits carry no information here.
  logic unused_bits;
  assign unused_bits = ^{bus.DataAdr[1:0], bus.WriteData[31:16]};

  assign hit_w  = (bus.DataAdr[31:5] == BASE_ADDR[31:5]);
  assign wr_w   = bus.MemWrite && hit_w;
  assign off_w  = bus.DataAdr[4:2];

  assign tick_w     = en_q && (pre_q == PRE_LAST);
  assign wrap_evt_w = tick_w && (cnt_q == per_sh_q);

  always_comb begin
    leds_d    = leds_q;
    period_d  = period_q;
    duty_d    = duty_q;
    en_d      = en_q;
    done_d    = done_q;
    cnt_d     = cnt_q;
    pre_d     = pre_q;
    per_sh_d  = per_sh_q;
    duty_sh_d = duty_sh_q;

    // Counter side works from pre-edge register values, so a PERIOD/DUTY
    // store landing on the wrap edge is only seen at the following wrap.
    if (!en_q) begin
      pre_d     = '0;
      cnt_d     = '0;
      per_sh_d  = period_q;
      duty_sh_d = duty_q;
    end else begin
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
      if (tick_w) begin
        // Equality compare only: a shadow below cnt lets cnt roll over 16 bits.
        cnt_d = wrap_evt_w ? 16'd0 : cnt_q + 16'd1;
      end
      if (wrap_evt_w) begin
        per_sh_d  = period_q;
        duty_sh_d = duty_q;
      end
    end

    if (wr_w) begin
      case (off_w)
        3'd0:    leds_d   = bus.WriteData[3:0];
        3'd1:    period_d = bus.WriteData[15:0];
        3'd2:    duty_d   = bus.WriteData[15:0];
        3'd3:    en_d     = bus.WriteData[0];
        3'd4:    if (bus.WriteData[0]) done_d = 1'b0;
        default: ;
      endcase
    end

    // Set after clear so a wrap on the clearing edge keeps DONE high.
    if (wrap_evt_w) done_d = 1'b1;

    // Compare against next-state values so the first period after enabling
    // already drives its full high time.
    pwm_d  = en_d && (cnt_d < duty_sh_d);
    wrap_d = wrap_evt_w;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      leds_q    <= '0;
      period_q  <= '0;
      duty_q    <= '0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      pre_q     <= '0;
      per_sh_q  <= '0;
      duty_sh_q <= '0;
      pwm_q     <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      leds_q    <= leds_d;
      period_q  <= period_d;
      duty_q    <= duty_d;
      en_q      <= en_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      pre_q     <= pre_d;
      per_sh_q  <= per_sh_d;
      duty_sh_q <= duty_sh_d;
      pwm_q     <= pwm_d;
      wrap_q    <= wrap_d;
    end
  end

  always_comb begin
    rdata_w = '0;
    if (hit_w) begin
      case (off_w)
        3'd0:    rdata_w = {28'd0, leds_q};
        3'd1:    rdata_w = {16'd0, period_q};
        3'd2:    rdata_w = {16'd0, duty_q};
        3'd3:    rdata_w = {31'd0, en_q};
        3'd4:    rdata_w = {31'd0, done_q};
        3'd5:    rdata_w = {16'd0, cnt_q};
        default: rdata_w = '0;
      endcase
    end
  end

  assign bus.ReadData = rdata_w;
  assign bus.hit      = hit_w;
  assign leds         = leds_q;
  assign pwm_out      = {31'd0, pwm_q};
  assign wrap         = wrap_q;

endmodule
